// File: rtl/segasys_hs_bus_router.sv
// Hiscore/debug bus router: decodes one requester bus onto NCH memory channels
// through base/mask windows, with req/ack handshake, per-channel read latency,
// pause gating and an unmapped-address error pulse.
module segasys_hs_bus_router #(
  parameter int              NCH        = 2,
  parameter int              AW         = 16,
  parameter logic [NCH*AW-1:0] CH_BASE  = {16'h0000, 16'hC000},
  parameter logic [NCH*AW-1:0] CH_MASK  = {16'h1000, 16'hF000},
  parameter int              RD_LAT     = 1,
  parameter logic [7:0]      DFLT       = 8'hFF,
  parameter bit              PAUSE_GATE = 1'b1
) (
  input  logic             CLK40M,
  input  logic             RESET_N,
  input  logic             PAUSE_N,
  input  logic [AW-1:0]    HSAD,
  input  logic [7:0]       HSDI,
  input  logic             HSWE,
  input  logic             HSREQ,
  output logic             HSACK,
  output logic [7:0]       HSDO,
  output logic             HSERR,
  output logic             HSBUSY,
  output logic [AW-1:0]    CH_AD,
  output logic [7:0]       CH_DO,
  output logic [NCH-1:0]   CH_WE,
  output logic [NCH-1:0]   CH_SEL,
  input  logic [NCH*8-1:0] CH_DI
);

  localparam int         IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAITP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t         state_r;
  logic [IW-1:0]  sel_idx_r;
  logic           we_r;
  logic [1:0]     lat_cnt_r;

  logic           hit_s;
  logic [IW-1:0]  hit_idx_s;
  logic [7:0]     rd_byte_s;

  // One-hot vector for a channel index.
  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Window decode of the live address; scanning downward lets the lowest index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((HSAD & CH_MASK[i*AW +: AW]) == (CH_BASE[i*AW +: AW] & CH_MASK[i*AW +: AW])) begin
        hit_s     = 1'b1;
        hit_idx_s = IW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Read-data mux for the channel latched at accept.
  always_comb begin
    rd_byte_s = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (sel_idx_r == IW'(i)) begin
        rd_byte_s = CH_DI[i*8 +: 8];
      end else begin
        rd_byte_s = rd_byte_s;
      end
    end
  end

  // Transaction FSM; every requester and channel output is a register here.
  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_IDLE;
      sel_idx_r <= '0;
      we_r      <= 1'b0;
      lat_cnt_r <= 2'd0;
      HSACK     <= 1'b0;
      HSDO      <= 8'h00;
      HSERR     <= 1'b0;
      HSBUSY    <= 1'b0;
      CH_AD     <= '0;
      CH_DO     <= 8'h00;
      CH_WE     <= '0;
      CH_SEL    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          HSACK  <= 1'b0;
          HSERR  <= 1'b0;
          CH_WE  <= '0;
          CH_SEL <= '0;
          if (HSREQ) begin
            // Latch everything now so later HSAD/HSDI/HSWE changes are ignored.
            CH_AD     <= HSAD;
            CH_DO     <= HSDI;
            we_r      <= HSWE;
            sel_idx_r <= hit_idx_s;
            lat_cnt_r <= 2'd0;
            HSBUSY    <= 1'b1;
            if (!hit_s) begin
              state_r <= ST_DONE;
              HSACK   <= 1'b1;
              HSERR   <= 1'b1;
              HSDO    <= HSWE ? HSDO : DFLT;
            end else if (!PAUSE_GATE || !PAUSE_N) begin
              state_r <= ST_ACCESS;
              CH_SEL  <= onehot(hit_idx_s);
              CH_WE   <= HSWE ? onehot(hit_idx_s) : '0;
            end else begin
              state_r <= ST_WAITP;
            end
          end else begin
            HSBUSY <= 1'b0;
          end
        end
        ST_WAITP: begin
          if (!PAUSE_N) begin
            state_r <= ST_ACCESS;
            CH_SEL  <= onehot(sel_idx_r);
            CH_WE   <= we_r ? onehot(sel_idx_r) : '0;
          end else begin
            state_r <= ST_WAITP;
          end
        end
        ST_ACCESS: begin
          // Write strobe is single-cycle; pause changes no longer matter here.
          CH_WE <= '0;
          if (we_r || (lat_cnt_r == LAT_LAST)) begin
            state_r <= ST_DONE;
            HSACK   <= 1'b1;
            CH_SEL  <= '0;
            HSDO    <= we_r ? HSDO : rd_byte_s;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          HSACK   <= 1'b0;
          HSERR   <= 1'b0;
          HSBUSY  <= 1'b0;
          CH_SEL  <= '0;
          CH_WE   <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
          HSACK   <= 1'b0;
          HSERR   <= 1'b0;
          HSBUSY  <= 1'b0;
          CH_SEL  <= '0;
          CH_WE   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segasys_hs_bus_router.sv
// Scoreboard bench for segasys_hs_bus_router: four channels with overlapping
// windows, 3-cycle read latency, pause gating, random traffic and a mid-access reset.
module tb_segasys_hs_bus_router;

  localparam int         NCH    = 4;
  localparam int         AW     = 16;
  localparam int         RD_LAT = 3;
  localparam logic [7:0] DFLT   = 8'hFF;
  localparam logic [15:0] BASE_T [4] = '{16'h0000, 16'hC000, 16'h4000, 16'hC000};
  localparam logic [15:0] MASK_T [4] = '{16'hF000, 16'hF000, 16'hC000, 16'hC000};

  logic             CLK40M = 1'b0;
  logic             RESET_N = 1'b0;
  logic             PAUSE_N = 1'b0;
  logic [AW-1:0]    HSAD = '0;
  logic [7:0]       HSDI = 8'h00;
  logic             HSWE = 1'b0;
  logic             HSREQ = 1'b0;
  logic             HSACK, HSERR, HSBUSY;
  logic [7:0]       HSDO, CH_DO;
  logic [AW-1:0]    CH_AD;
  logic [NCH-1:0]   CH_WE, CH_SEL;
  logic [NCH*8-1:0] CH_DI;

  segasys_hs_bus_router #(
    .NCH(NCH), .AW(AW),
    .CH_BASE({BASE_T[3], BASE_T[2], BASE_T[1], BASE_T[0]}),
    .CH_MASK({MASK_T[3], MASK_T[2], MASK_T[1], MASK_T[0]}),
    .RD_LAT(RD_LAT), .DFLT(DFLT), .PAUSE_GATE(1'b1)
  ) dut (
    .CLK40M(CLK40M), .RESET_N(RESET_N), .PAUSE_N(PAUSE_N),
    .HSAD(HSAD), .HSDI(HSDI), .HSWE(HSWE), .HSREQ(HSREQ),
    .HSACK(HSACK), .HSDO(HSDO), .HSERR(HSERR), .HSBUSY(HSBUSY),
    .CH_AD(CH_AD), .CH_DO(CH_DO), .CH_WE(CH_WE), .CH_SEL(CH_SEL), .CH_DI(CH_DI)
  );

  always #5 CLK40M = ~CLK40M;

  typedef struct {
    int         acc;
    int         nwait;
    int         ch;
    bit         we;
    logic [7:0] data;
    logic [15:0] addr;
    logic [7:0] hsdo;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mon_hsdo = 8'h00;
  logic [7:0] hsdo_model = 8'h00;
  logic [7:0] env_mem [NCH][256];
  logic [7:0] mem_model [NCH][256];

  always @(posedge CLK40M) cyc <= cyc + 1;

  // Channel memories seen by the DUT.
  always_comb begin
    CH_DI = '0;
    for (int c = 0; c < NCH; c++) CH_DI[c*8 +: 8] = env_mem[c][CH_AD[7:0]];
  end

  always @(posedge CLK40M) begin
    for (int c = 0; c < NCH; c++)
      if (CH_WE[c]) env_mem[c][CH_AD[7:0]] <= CH_DO;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [15:0] a);
    for (int i = 0; i < NCH; i++)
      if ((a & MASK_T[i]) == (BASE_T[i] & MASK_T[i])) return i;
    return -1;
  endfunction

  // Monitor: per-cycle expectation derived from the head of the scoreboard.
  logic [10:0] mon_exp_v;
  int          mon_ack;
  exp_t        mon_e;
  always @(negedge CLK40M) begin
    if (mon_en && RESET_N) begin
      mon_exp_v = '0;
      mon_ack   = -1;
      if (q.size() > 0) begin
        mon_e   = q[0];
        mon_ack = mon_e.acc + ((mon_e.ch < 0) ? 0 : ((mon_e.we ? 1 : RD_LAT) + mon_e.nwait));
        if (cyc >= mon_e.acc && cyc <= mon_ack) mon_exp_v[8] = 1'b1;
        if (cyc == mon_ack) begin
          mon_exp_v[10] = 1'b1;
          mon_exp_v[9]  = (mon_e.ch < 0);
          mon_hsdo      = mon_e.hsdo;
        end
        if (mon_e.ch >= 0 && cyc >= mon_e.acc + mon_e.nwait && cyc < mon_ack) begin
          mon_exp_v[3:0] = 4'(1 << mon_e.ch);
          if (mon_e.we) begin
            mon_exp_v[7:4] = 4'(1 << mon_e.ch);
            chk("ch_ad", 64'(CH_AD), 64'(mon_e.addr));
            chk("ch_do", 64'(CH_DO), 64'(mon_e.data));
          end
        end
      end
      chk("ack_err_busy_we_sel", 64'({HSACK, HSERR, HSBUSY, CH_WE, CH_SEL}), 64'(mon_exp_v));
      chk("hsdo", 64'(HSDO), 64'(mon_hsdo));
      if (cyc == mon_ack) void'(q.pop_front());
    end
  end

  // Issue one transaction starting at a negedge; returns at the ACK negedge.
  task automatic do_txn(input logic [15:0] addr, input logic [7:0] data, input bit we,
                        input int nwait, input bit b2b);
    exp_t e;
    int   n;
    if (!b2b) begin
      HSREQ = 1'b0;
      @(negedge CLK40M);
    end
    HSAD    = addr;
    HSDI    = data;
    HSWE    = we;
    HSREQ   = 1'b1;
    PAUSE_N = (nwait > 0);
    e.acc   = cyc + (b2b ? 2 : 1);
    e.ch    = decode(addr);
    e.nwait = (e.ch < 0) ? 0 : nwait;
    e.we    = we;
    e.data  = data;
    e.addr  = addr;
    if (e.ch >= 0 && we) mem_model[e.ch][addr[7:0]] = data;
    else if (e.ch >= 0) hsdo_model = mem_model[e.ch][addr[7:0]];
    else if (!we) hsdo_model = DFLT;
    e.hsdo = hsdo_model;
    q.push_back(e);
    n = 0;
    while (cyc < e.acc && n < 10) begin
      @(negedge CLK40M);
      n++;
    end
    HSAD = 16'($urandom);
    HSDI = 8'($urandom);
    HSWE = 1'($urandom_range(0, 1));
    if (e.ch >= 0) begin
      if (nwait > 0) begin
        repeat (nwait - 1) @(negedge CLK40M);
        PAUSE_N = 1'b0;
        @(negedge CLK40M);
      end
      if (!we && $urandom_range(0, 1) == 1) PAUSE_N = 1'b1;
    end
    n = 0;
    while (!HSACK && n < 40) begin
      @(negedge CLK40M);
      n++;
    end
    if (!HSACK) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [7:0] hi_tab [6];
    logic [15:0] a;
    hi_tab = '{8'h00, 8'hC0, 8'h40, 8'hE0, 8'h80, 8'h10};
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 256; i++) begin
        env_mem[c][i]   = 8'(c * 37 + i) ^ 8'hA5;
        mem_model[c][i] = 8'(c * 37 + i) ^ 8'hA5;
      end

    // Reset state
    @(negedge CLK40M);
    chk("reset_outputs", 64'({HSACK, HSDO, HSERR, HSBUSY, CH_AD, CH_DO, CH_WE, CH_SEL}), 64'(0));
    repeat (2) @(negedge CLK40M);
    RESET_N = 1'b1;
    mon_en  = 1'b1;
    @(negedge CLK40M);

    // Directed: paused read ch1, paused write ch0, read-back, unmapped read,
    // write behind a 5-cycle pause, overlap read (ch1 wins) then back-to-back read.
    do_txn(16'hC010, 8'h00, 1'b0, 0, 1'b0);
    do_txn(16'h0123, 8'h3C, 1'b1, 0, 1'b0);
    do_txn(16'h0123, 8'h00, 1'b0, 0, 1'b0);
    do_txn(16'h8000, 8'h11, 1'b0, 2, 1'b0);
    do_txn(16'hC000, 8'h96, 1'b1, 5, 1'b0);
    do_txn(16'hE004, 8'h00, 1'b0, 1, 1'b0);
    do_txn(16'hC000, 8'h00, 1'b0, 0, 1'b1);
    do_txn(16'hC000, 8'h00, 1'b0, 0, 1'b1);
    do_txn(16'h9000, 8'h22, 1'b1, 0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 80; t++) begin
      a = {hi_tab[$urandom_range(0, 5)], 8'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      do_txn(a, 8'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             1'($urandom_range(0, 1)));
    end

    // Reset in the ACCESS cycle of a write: no ACK, no write committed.
    HSREQ = 1'b0;
    @(negedge CLK40M);
    mon_en  = 1'b0;
    HSAD    = 16'h0005;
    HSDI    = 8'h77;
    HSWE    = 1'b1;
    PAUSE_N = 1'b0;
    HSREQ   = 1'b1;
    @(negedge CLK40M);
    chk("pre_reset_we", 64'(CH_WE), 64'(4'b0001));
    #2 RESET_N = 1'b0;
    #1 chk("async_reset_outputs",
           64'({HSACK, HSDO, HSERR, HSBUSY, CH_AD, CH_DO, CH_WE, CH_SEL}), 64'(0));
    HSREQ = 1'b0;
    q.delete();
    repeat (3) begin
      @(negedge CLK40M);
      chk("reset_hold_ack_we", 64'({HSACK, CH_WE}), 64'(0));
    end
    RESET_N    = 1'b1;
    mon_hsdo   = 8'h00;
    hsdo_model = 8'h00;
    mon_en     = 1'b1;
    @(negedge CLK40M);
    do_txn(16'h0005, 8'h00, 1'b0, 0, 1'b0);
    HSREQ = 1'b0;
    repeat (3) @(negedge CLK40M);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
